// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-style control unit: Moore-decoded datapath controls,
// sticky illegal-opcode trap and a wrapping retired-instruction counter.
module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Op,
  input  logic        Zero,
  input  logic        MemRdy,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MRead,
  output logic        MWrite,
  output logic        IRWrite,
  output logic        RegDs,
  output logic        MtoR,
  output logic        Urw,
  output logic        ALUsrcA,
  output logic [1:0]  ALUsrcB,
  output logic [2:0]  AOp,
  output logic        PCSrc,
  output logic        Trap,
  output logic [15:0] InstrCnt
);

  localparam int unsigned CNT_W = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] AOP_RFN = 3'b010;
  localparam logic [2:0] AOP_ADD = 3'b011;
  localparam logic [2:0] AOP_SUB = 3'b001;
  localparam logic [2:0] AOP_AND = 3'b101;
  localparam logic [2:0] AOP_OR  = 3'b110;
  localparam logic [2:0] AOP_SLT = 3'b100;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWR  = 4'd5,
    MEMWB  = 4'd6,
    REXEC  = 4'd7,
    RWB    = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    BRANCH = 4'd11,
    TRAP   = 4'd12
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             run_q;
  logic             retire;
  logic [CNT_W-1:0] instr_cnt;

  // Reset deasserts synchronously: IDLE holds one extra edge so the first
  // FETCH lands on the second rising edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  assign InstrCnt = instr_cnt;

  // Next-state, Moore outputs and retire strobe
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    PCWrite = 1'b0;
    IorD    = 1'b0;
    MRead   = 1'b0;
    MWrite  = 1'b0;
    IRWrite = 1'b0;
    RegDs   = 1'b0;
    MtoR    = 1'b0;
    Urw     = 1'b0;
    ALUsrcA = 1'b0;
    ALUsrcB = 2'b00;
    AOp     = 3'b000;
    PCSrc   = 1'b0;
    Trap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_q) state_d = FETCH;
      end
      FETCH: begin
        MRead   = 1'b1;
        ALUsrcB = 2'b01;
        AOp     = AOP_ADD;
        IRWrite = MemRdy;
        PCWrite = MemRdy;
        if (MemRdy) state_d = DECODE;
      end
      DECODE: begin
        ALUsrcB = 2'b11;
        AOp     = AOP_ADD;
        case (Op)
          OP_RTYPE:                         state_d = REXEC;
          OP_LW, OP_SW:                     state_d = MEMADR;
          OP_BEQ:                           state_d = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IEXEC;
          default:                          state_d = TRAP;
        endcase
      end
      MEMADR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        AOp     = AOP_ADD;
        case (Op)
          OP_LW:   state_d = MEMRD;
          OP_SW:   state_d = MEMWR;
          default: state_d = TRAP;
        endcase
      end
      MEMRD: begin
        MRead = 1'b1;
        IorD  = 1'b1;
        if (MemRdy) state_d = MEMWB;
      end
      MEMWR: begin
        MWrite = 1'b1;
        IorD   = 1'b1;
        if (MemRdy) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      MEMWB: begin
        Urw     = 1'b1;
        MtoR    = 1'b1;
        state_d = FETCH;
        retire  = 1'b1;
      end
      REXEC: begin
        ALUsrcA = 1'b1;
        AOp     = AOP_RFN;
        state_d = RWB;
      end
      RWB: begin
        Urw     = 1'b1;
        RegDs   = 1'b1;
        state_d = FETCH;
        retire  = 1'b1;
      end
      IEXEC: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        case (Op)
          OP_ADDI: AOp = AOP_ADD;
          OP_ANDI: AOp = AOP_AND;
          OP_ORI:  AOp = AOP_OR;
          OP_SLTI: AOp = AOP_SLT;
          default: AOp = 3'b000;
        endcase
        state_d = IWB;
      end
      IWB: begin
        Urw     = 1'b1;
        state_d = FETCH;
        retire  = 1'b1;
      end
      BRANCH: begin
        ALUsrcA = 1'b1;
        AOp     = AOP_SUB;
        PCSrc   = 1'b1;
        PCWrite = Zero;
        state_d = FETCH;
        retire  = 1'b1;
      end
      TRAP: begin
        Trap = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks R-type, LW, SW, BEQ, I-type and
// trap sequences with hand-computed per-cycle control vectors.
module tb_mc_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic [5:0]  Op;
  logic        Zero;
  logic        MemRdy;
  logic        PCWrite, IorD, MRead, MWrite, IRWrite, RegDs, MtoR, Urw;
  logic        ALUsrcA, PCSrc, Trap;
  logic [1:0]  ALUsrcB;
  logic [2:0]  AOp;
  logic [15:0] InstrCnt;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;
  int irw      = 0;
  int pcw      = 0;
  int mrd      = 0;

  // Vector layout: PCWrite IorD MRead MWrite IRWrite RegDs MtoR Urw
  //                ALUsrcA ALUsrcB[1:0] AOp[2:0] PCSrc Trap
  localparam logic [15:0] E_IDLE   = 16'h0000;
  localparam logic [15:0] E_FETCH0 = 16'h202C;
  localparam logic [15:0] E_FETCH1 = 16'hA82C;
  localparam logic [15:0] E_DEC    = 16'h006C;
  localparam logic [15:0] E_MADR   = 16'h00CC;
  localparam logic [15:0] E_MRD    = 16'h6000;
  localparam logic [15:0] E_MWR    = 16'h5000;
  localparam logic [15:0] E_MWB    = 16'h0300;
  localparam logic [15:0] E_REXEC  = 16'h0088;
  localparam logic [15:0] E_RWB    = 16'h0500;
  localparam logic [15:0] E_ADDI   = 16'h00CC;
  localparam logic [15:0] E_ORI    = 16'h00D8;
  localparam logic [15:0] E_IWB    = 16'h0100;
  localparam logic [15:0] E_BRT    = 16'h8086;
  localparam logic [15:0] E_BRN    = 16'h0086;
  localparam logic [15:0] E_TRAP   = 16'h0001;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .MemRdy(MemRdy),
    .PCWrite(PCWrite), .IorD(IorD), .MRead(MRead), .MWrite(MWrite),
    .IRWrite(IRWrite), .RegDs(RegDs), .MtoR(MtoR), .Urw(Urw),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .AOp(AOp), .PCSrc(PCSrc),
    .Trap(Trap), .InstrCnt(InstrCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [15:0] outs();
    return {PCWrite, IorD, MRead, MWrite, IRWrite, RegDs, MtoR, Urw,
            ALUsrcA, ALUsrcB, AOp, PCSrc, Trap};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs and counter, advance.
  task automatic cyc(input string tag, input logic mr, input logic z,
                     input logic [15:0] exp, input logic [15:0] expcnt);
    MemRdy = mr;
    Zero   = z;
    #1;
    chk({tag, ".out"}, outs(), exp);
    chk({tag, ".cnt"}, InstrCnt, expcnt);
    irw  += int'(IRWrite);
    pcw  += int'(PCWrite);
    mrd  += int'(MRead);
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    Op     = OP_R;
    Zero   = 1'b0;
    MemRdy = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out", outs(), E_IDLE);
    chk("rst.cnt", InstrCnt, 16'h0000);

    // Release: IDLE after edge 1, FETCH after edge 2
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel.edge1", outs(), E_IDLE);
    @(posedge clk); #1;

    // R-type, MemRdy held high
    Op = OP_R; ncyc = 0;
    cyc("r.fetch", 1'b1, 1'b0, E_FETCH1, 16'd0);
    cyc("r.dec",   1'b1, 1'b0, E_DEC,    16'd0);
    cyc("r.exec",  1'b1, 1'b0, E_REXEC,  16'd0);
    cyc("r.wb",    1'b1, 1'b0, E_RWB,    16'd0);
    chk("r.cycles", 16'(ncyc), 16'd4);

    // LW with 3 wait cycles in FETCH and MEMRD
    Op = OP_LW; ncyc = 0; irw = 0; pcw = 0; mrd = 0;
    cyc("lw.f1",  1'b0, 1'b0, E_FETCH0, 16'd1);
    cyc("lw.f2",  1'b0, 1'b0, E_FETCH0, 16'd1);
    cyc("lw.f3",  1'b0, 1'b0, E_FETCH0, 16'd1);
    cyc("lw.f4",  1'b1, 1'b0, E_FETCH1, 16'd1);
    cyc("lw.dec", 1'b1, 1'b0, E_DEC,    16'd1);
    cyc("lw.adr", 1'b1, 1'b0, E_MADR,   16'd1);
    cyc("lw.r1",  1'b0, 1'b0, E_MRD,    16'd1);
    cyc("lw.r2",  1'b0, 1'b0, E_MRD,    16'd1);
    cyc("lw.r3",  1'b0, 1'b0, E_MRD,    16'd1);
    cyc("lw.r4",  1'b1, 1'b0, E_MRD,    16'd1);
    cyc("lw.wb",  1'b0, 1'b0, E_MWB,    16'd1);
    chk("lw.cycles",  16'(ncyc), 16'd11);
    chk("lw.irwrite", 16'(irw),  16'd1);
    chk("lw.pcwrite", 16'(pcw),  16'd1);
    chk("lw.mread",   16'(mrd),  16'd8);

    // BEQ taken then not taken
    Op = OP_BEQ;
    cyc("beq1.f",   1'b1, 1'b0, E_FETCH1, 16'd2);
    cyc("beq1.dec", 1'b1, 1'b1, E_DEC,    16'd2);
    cyc("beq1.br",  1'b1, 1'b1, E_BRT,    16'd2);
    cyc("beq2.f",   1'b1, 1'b0, E_FETCH1, 16'd3);
    cyc("beq2.dec", 1'b1, 1'b0, E_DEC,    16'd3);
    cyc("beq2.br",  1'b1, 1'b0, E_BRN,    16'd3);

    // ORI and ADDI
    Op = OP_ORI;
    cyc("ori.f",    1'b1, 1'b0, E_FETCH1, 16'd4);
    cyc("ori.dec",  1'b1, 1'b0, E_DEC,    16'd4);
    cyc("ori.exec", 1'b1, 1'b0, E_ORI,    16'd4);
    cyc("ori.wb",   1'b1, 1'b0, E_IWB,    16'd4);
    Op = OP_ADDI;
    cyc("addi.f",    1'b1, 1'b0, E_FETCH1, 16'd5);
    cyc("addi.dec",  1'b1, 1'b0, E_DEC,    16'd5);
    cyc("addi.exec", 1'b1, 1'b0, E_ADDI,   16'd5);
    cyc("addi.wb",   1'b1, 1'b0, E_IWB,    16'd5);

    // Preload the counter to 0xFFFF while parked in FETCH
    MemRdy = 1'b0;
    force dut.instr_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.instr_cnt;

    // SW wraps the counter
    Op = OP_SW;
    cyc("sw.f",   1'b1, 1'b0, E_FETCH1, 16'hFFFF);
    cyc("sw.dec", 1'b0, 1'b0, E_DEC,    16'hFFFF);
    cyc("sw.adr", 1'b0, 1'b0, E_MADR,   16'hFFFF);
    cyc("sw.w1",  1'b0, 1'b0, E_MWR,    16'hFFFF);
    cyc("sw.w2",  1'b1, 1'b0, E_MWR,    16'hFFFF);
    Op = OP_ADDI;
    cyc("wrap.f",    1'b1, 1'b0, E_FETCH1, 16'h0000);
    cyc("wrap.dec",  1'b1, 1'b0, E_DEC,    16'h0000);
    cyc("wrap.exec", 1'b1, 1'b0, E_ADDI,   16'h0000);
    cyc("wrap.wb",   1'b1, 1'b0, E_IWB,    16'h0000);

    // Illegal opcode: sticky trap, counter frozen
    Op = OP_BAD;
    cyc("bad.f",   1'b1, 1'b0, E_FETCH1, 16'd1);
    cyc("bad.dec", 1'b1, 1'b0, E_DEC,    16'd1);
    for (int i = 0; i < 20; i++)
      cyc("trap", i[0], ~i[1], E_TRAP, 16'd1);

    rst_n = 1'b0;
    #1;
    chk("trap.rst.out", outs(), E_IDLE);
    chk("trap.rst.cnt", InstrCnt, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel2.edge1", outs(), E_IDLE);
    @(posedge clk); #1;

    // Reset during a stalled MEMWR
    Op = OP_SW;
    cyc("swr.f",   1'b1, 1'b0, E_FETCH1, 16'd0);
    cyc("swr.dec", 1'b0, 1'b0, E_DEC,    16'd0);
    cyc("swr.adr", 1'b0, 1'b0, E_MADR,   16'd0);
    MemRdy = 1'b0;
    #1;
    chk("swr.wr", outs(), E_MWR);
    rst_n = 1'b0;
    #1;
    chk("swr.rst.out", outs(), E_IDLE);
    chk("swr.rst.cnt", InstrCnt, 16'h0000);
    MemRdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("swr.hold.out", outs(), E_IDLE);
      chk("swr.hold.cnt", InstrCnt, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
